// File: rtl/match_mem_arbiter.sv
// rtl/match_mem_arbiter.sv - arbitrates the match-record SRAM between capture bursts and host reads
module match_mem_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 10,
  parameter int RD_LATENCY = 2
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              cap_req,
  input  logic              cap_valid,
  input  logic [DATA_W-1:0] cap_data,
  input  logic              cap_last,
  output logic              cap_ready,
  input  logic              host_read,
  input  logic [ADDR_W-1:0] host_address,
  output logic              host_waitrequest,
  output logic [DATA_W-1:0] host_readdata,
  output logic              host_readdatavalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              clr_ptr,
  output logic [ADDR_W:0]   wr_ptr,
  output logic              buf_full,
  output logic              overflow
);

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(2**ADDR_W);

  typedef enum logic [1:0] {IDLE, CAP_WRITE, HOST_READ, HOST_WAIT} state_t;
  typedef enum logic {PRIO_CAP, PRIO_HOST} prio_t;

  state_t state, state_nxt;
  prio_t  prio, prio_nxt;

  // rd_vld[k] set means a read was issued k+1 cycles ago; the top bit marks
  // the cycle mem_rdata is valid and doubles as the HOST_WAIT exit timer.
  logic [RD_LATENCY-1:0] rd_vld;

  logic cap_word;

  assign cap_word           = (state == CAP_WRITE) && cap_valid;
  assign buf_full           = (wr_ptr == DEPTH);
  assign host_readdatavalid = rd_vld[RD_LATENCY-1];
  assign host_readdata      = host_readdatavalid ? mem_rdata : '0;

  // State and grant-priority registers.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state <= IDLE;
      prio  <= PRIO_CAP;
    end else begin
      state <= state_nxt;
      prio  <= prio_nxt;
    end
  end

  // Next-state decode and combinational SRAM / handshake outputs.
  always_comb begin
    state_nxt        = state;
    prio_nxt         = prio;
    cap_ready        = 1'b0;
    host_waitrequest = 1'b1;
    mem_we           = 1'b0;
    mem_re           = 1'b0;
    mem_addr         = '0;
    mem_wdata        = '0;
    case (state)
      IDLE: begin
        if (cap_req && (!host_read || prio == PRIO_CAP)) begin
          state_nxt = CAP_WRITE;
          prio_nxt  = PRIO_HOST;
        end else if (host_read) begin
          state_nxt = HOST_READ;
          prio_nxt  = PRIO_CAP;
        end
      end
      CAP_WRITE: begin
        // Ready stays high while full so the FIFO drains; excess words are dropped.
        cap_ready = 1'b1;
        if (cap_valid && !buf_full) begin
          mem_we    = 1'b1;
          mem_addr  = wr_ptr[ADDR_W-1:0];
          mem_wdata = cap_data;
        end
        if (cap_valid && cap_last) state_nxt = IDLE;
      end
      HOST_READ: begin
        mem_re           = 1'b1;
        mem_addr         = host_address;
        host_waitrequest = 1'b0;
        state_nxt        = HOST_WAIT;
      end
      HOST_WAIT: begin
        if (rd_vld[RD_LATENCY-1]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read-valid pipeline; reset flushes it so an aborted read never returns data.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      rd_vld <= '0;
    end else begin
      for (int i = RD_LATENCY - 1; i >= 1; i--) rd_vld[i] <= rd_vld[i-1];
      rd_vld[0] <= (state == HOST_READ);
    end
  end

  // Write pointer (saturating) and sticky overflow; a host clear beats an increment.
  always_ff @(posedge clk) begin
    if (n_rst || clr_ptr) begin
      wr_ptr   <= '0;
      overflow <= 1'b0;
    end else if (cap_word) begin
      if (!buf_full) wr_ptr   <= wr_ptr + (ADDR_W+1)'(1);
      else           overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_match_mem_arbiter.sv
// tb/tb_match_mem_arbiter.sv - directed self-checking bench for match_mem_arbiter
module tb_match_mem_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 3;
  localparam int RD_LAT = 2;

  logic              clk = 1'b0;
  logic              n_rst;
  logic              cap_req, cap_valid, cap_last, cap_ready;
  logic [DATA_W-1:0] cap_data;
  logic              host_read, host_waitrequest, host_readdatavalid;
  logic [ADDR_W-1:0] host_address;
  logic [DATA_W-1:0] host_readdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              mem_we, mem_re;
  logic              clr_ptr;
  logic [ADDR_W:0]   wr_ptr;
  logic              buf_full, overflow;

  int vecs = 0;
  int errs = 0;

  match_mem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LATENCY(RD_LAT)) dut (
    .clk(clk), .n_rst(n_rst),
    .cap_req(cap_req), .cap_valid(cap_valid), .cap_data(cap_data), .cap_last(cap_last),
    .cap_ready(cap_ready),
    .host_read(host_read), .host_address(host_address), .host_waitrequest(host_waitrequest),
    .host_readdata(host_readdata), .host_readdatavalid(host_readdatavalid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata),
    .clr_ptr(clr_ptr), .wr_ptr(wr_ptr), .buf_full(buf_full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // SRAM model with a two-cycle read pipeline
  logic [DATA_W-1:0] sram [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rd_p1, rd_p2;
  initial begin
    for (int i = 0; i < (1<<ADDR_W); i++) sram[i] = '0;
    rd_p1 = '0;
    rd_p2 = '0;
  end
  always @(posedge clk) begin
    if (mem_we) sram[mem_addr] <= mem_wdata;
    rd_p1 <= mem_re ? sram[mem_addr] : '0;
    rd_p2 <= rd_p1;
  end
  assign mem_rdata = rd_p2;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    n_rst = 1'b1; cap_req = 0; cap_valid = 0; cap_last = 0; cap_data = '0;
    host_read = 0; host_address = '0; clr_ptr = 0;
    tick();
    tick();
    n_rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_rst = 1'b1;
    #1;
    vecs++; if (cap_ready !== 1'b0) begin errs++; $display("FAIL reset_cap_ready: got %h want 0", cap_ready); end
    vecs++; if (mem_we !== 1'b0 || mem_re !== 1'b0) begin errs++; $display("FAIL reset_mem_en: got we=%h re=%h want 0 0", mem_we, mem_re); end
    vecs++; if (host_waitrequest !== 1'b1) begin errs++; $display("FAIL reset_waitreq: got %h want 1", host_waitrequest); end
    vecs++; if (host_readdatavalid !== 1'b0 || host_readdata !== '0) begin errs++; $display("FAIL reset_readdata: got v=%h d=%h want 0 0", host_readdatavalid, host_readdata); end
    vecs++; if (mem_addr !== '0 || mem_wdata !== '0) begin errs++; $display("FAIL reset_mem_bus: got a=%h d=%h want 0 0", mem_addr, mem_wdata); end
    vecs++; if (wr_ptr !== '0 || overflow !== 1'b0 || buf_full !== 1'b0) begin errs++; $display("FAIL reset_status: got ptr=%0d ovf=%h full=%h want 0 0 0", wr_ptr, overflow, buf_full); end
    n_rst = 1'b0;
  endtask

  task automatic test_capture();
    cap_req = 1'b1;
    #1;
    vecs++; if (cap_ready !== 1'b0) begin errs++; $display("FAIL cap_idle_ready: got %h want 0", cap_ready); end
    tick();
    for (int i = 0; i < 4; i++) begin
      cap_valid = 1'b1; cap_data = 32'hA0 + i; cap_last = (i == 3); cap_req = (i != 3);
      #1;
      vecs++; if (cap_ready !== 1'b1 || mem_we !== 1'b1) begin errs++; $display("FAIL cap_word%0d_we: got rdy=%h we=%h want 1 1", i, cap_ready, mem_we); end
      vecs++; if (mem_addr !== 3'(i) || mem_wdata !== 32'hA0 + i) begin errs++; $display("FAIL cap_word%0d_bus: got a=%h d=%h want %h %h", i, mem_addr, mem_wdata, i, 32'hA0 + i); end
      vecs++; if (host_waitrequest !== 1'b1) begin errs++; $display("FAIL cap_word%0d_wait: got %h want 1", i, host_waitrequest); end
      tick();
    end
    cap_valid = 1'b0; cap_last = 1'b0;
    #1;
    vecs++; if (cap_ready !== 1'b0 || mem_we !== 1'b0) begin errs++; $display("FAIL cap_end: got rdy=%h we=%h want 0 0", cap_ready, mem_we); end
    vecs++; if (wr_ptr !== 4'd4) begin errs++; $display("FAIL cap_wr_ptr: got %0d want 4", wr_ptr); end
  endtask

  task automatic test_host_read();
    host_read = 1'b1; host_address = 3'd2;
    tick();
    #1;
    vecs++; if (host_waitrequest !== 1'b0 || mem_re !== 1'b1 || mem_addr !== 3'd2) begin errs++; $display("FAIL rd_cmd: got wr=%h re=%h a=%h want 0 1 2", host_waitrequest, mem_re, mem_addr); end
    host_read = 1'b0;
    tick();
    vecs++; if (host_readdatavalid !== 1'b0 || host_waitrequest !== 1'b1 || mem_re !== 1'b0) begin errs++; $display("FAIL rd_t1: got v=%h wr=%h re=%h want 0 1 0", host_readdatavalid, host_waitrequest, mem_re); end
    tick();
    vecs++; if (host_readdatavalid !== 1'b1 || host_readdata !== 32'hA2) begin errs++; $display("FAIL rd_t2_data: got v=%h d=%h want 1 a2", host_readdatavalid, host_readdata); end
    tick();
    host_read = 1'b1; host_address = 3'd0;
    #1;
    vecs++; if (host_readdatavalid !== 1'b0 || host_waitrequest !== 1'b1) begin errs++; $display("FAIL rd_t3_idle: got v=%h wr=%h want 0 1", host_readdatavalid, host_waitrequest); end
    tick();
    vecs++; if (host_waitrequest !== 1'b0 || mem_addr !== 3'd0) begin errs++; $display("FAIL rd_t4_regrant: got wr=%h a=%h want 0 0", host_waitrequest, mem_addr); end
    host_read = 1'b0;
    tick();
    tick();
    vecs++; if (host_readdatavalid !== 1'b1 || host_readdata !== 32'hA0) begin errs++; $display("FAIL rd2_data: got v=%h d=%h want 1 a0", host_readdatavalid, host_readdata); end
    tick();
  endtask

  task automatic test_contention();
    do_reset();
    cap_req = 1'b1; host_read = 1'b1; host_address = 3'd1;
    tick();
    cap_valid = 1'b1; cap_data = 32'hB0; cap_last = 1'b0;
    #1;
    vecs++; if (cap_ready !== 1'b1 || host_waitrequest !== 1'b1) begin errs++; $display("FAIL arb_cap_first: got rdy=%h wr=%h want 1 1", cap_ready, host_waitrequest); end
    tick();
    cap_data = 32'hB1; cap_last = 1'b1;
    tick();
    cap_valid = 1'b0; cap_last = 1'b0;
    #1;
    vecs++; if (cap_ready !== 1'b0 || host_waitrequest !== 1'b1) begin errs++; $display("FAIL arb_idle_gap: got rdy=%h wr=%h want 0 1", cap_ready, host_waitrequest); end
    tick();
    vecs++; if (host_waitrequest !== 1'b0 || cap_ready !== 1'b0 || mem_addr !== 3'd1) begin errs++; $display("FAIL arb_host_second: got wr=%h rdy=%h a=%h want 0 0 1", host_waitrequest, cap_ready, mem_addr); end
    host_read = 1'b0;
    tick();
    tick();
    vecs++; if (host_readdatavalid !== 1'b1 || host_readdata !== 32'hB1) begin errs++; $display("FAIL arb_host_data: got v=%h d=%h want 1 b1", host_readdatavalid, host_readdata); end
    tick();
    host_read = 1'b1;
    tick();
    vecs++; if (cap_ready !== 1'b1 || host_waitrequest !== 1'b1) begin errs++; $display("FAIL arb_cap_third: got rdy=%h wr=%h want 1 1", cap_ready, host_waitrequest); end
    cap_req = 1'b0; host_read = 1'b0;
    cap_valid = 1'b1; cap_data = 32'hB2; cap_last = 1'b1;
    #1;
    vecs++; if (mem_we !== 1'b1 || mem_addr !== 3'd2) begin errs++; $display("FAIL arb_cap_addr: got we=%h a=%h want 1 2", mem_we, mem_addr); end
    tick();
    cap_valid = 1'b0; cap_last = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset();
    cap_req = 1'b1;
    tick();
    cap_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cap_valid = 1'b1; cap_data = 32'hE0 + i; cap_last = (i == 9);
      #1;
      if (i < 8) begin
        vecs++; if (mem_we !== 1'b1 || mem_addr !== 3'(i)) begin errs++; $display("FAIL ovf_write%0d: got we=%h a=%h want 1 %h", i, mem_we, mem_addr, i); end
      end else begin
        vecs++; if (mem_we !== 1'b0 || cap_ready !== 1'b1 || buf_full !== 1'b1) begin errs++; $display("FAIL ovf_drop%0d: got we=%h rdy=%h full=%h want 0 1 1", i, mem_we, cap_ready, buf_full); end
        vecs++; if (overflow !== (i == 9)) begin errs++; $display("FAIL ovf_flag%0d: got %h want %h", i, overflow, (i == 9)); end
      end
      tick();
    end
    cap_valid = 1'b0; cap_last = 1'b0;
    #1;
    vecs++; if (wr_ptr !== 4'd8 || buf_full !== 1'b1 || overflow !== 1'b1) begin errs++; $display("FAIL ovf_status: got ptr=%0d full=%h ovf=%h want 8 1 1", wr_ptr, buf_full, overflow); end
  endtask

  task automatic test_clear();
    clr_ptr = 1'b1;
    tick();
    clr_ptr = 1'b0;
    #1;
    vecs++; if (wr_ptr !== '0 || buf_full !== 1'b0 || overflow !== 1'b0) begin errs++; $display("FAIL clr_status: got ptr=%0d full=%h ovf=%h want 0 0 0", wr_ptr, buf_full, overflow); end
    cap_req = 1'b1;
    tick();
    cap_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      logic [ADDR_W-1:0] exp_a;
      exp_a = (i == 2) ? 3'd0 : 3'(i);
      cap_valid = 1'b1; cap_data = 32'hC0 + i; cap_last = (i == 2); clr_ptr = (i == 1);
      #1;
      vecs++; if (mem_we !== 1'b1 || mem_addr !== exp_a || mem_wdata !== 32'hC0 + i) begin errs++; $display("FAIL clr_write%0d: got we=%h a=%h d=%h want 1 %h %h", i, mem_we, mem_addr, mem_wdata, exp_a, 32'hC0 + i); end
      if (i == 2) begin
        vecs++; if (wr_ptr !== '0) begin errs++; $display("FAIL clr_beats_inc: got %0d want 0", wr_ptr); end
      end
      tick();
    end
    cap_valid = 1'b0; cap_last = 1'b0; clr_ptr = 1'b0;
    #1;
    vecs++; if (wr_ptr !== 4'd1) begin errs++; $display("FAIL clr_after_burst: got %0d want 1", wr_ptr); end
  endtask

  task automatic test_reset_abort();
    do_reset();
    cap_req = 1'b1;
    tick();
    cap_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cap_valid = 1'b1; cap_data = 32'hD0 + i; cap_last = 1'b0;
      tick();
    end
    cap_valid = 1'b0;
    #1;
    vecs++; if (wr_ptr !== 4'd2 || cap_ready !== 1'b1) begin errs++; $display("FAIL abort_mid_burst: got ptr=%0d rdy=%h want 2 1", wr_ptr, cap_ready); end
    n_rst = 1'b1;
    tick();
    n_rst = 1'b0;
    #1;
    vecs++; if (cap_ready !== 1'b0 || wr_ptr !== '0 || host_waitrequest !== 1'b1) begin errs++; $display("FAIL abort_cap: got rdy=%h ptr=%0d wr=%h want 0 0 1", cap_ready, wr_ptr, host_waitrequest); end
    host_read = 1'b1; host_address = 3'd3;
    tick();
    vecs++; if (host_waitrequest !== 1'b0) begin errs++; $display("FAIL abort_rd_cmd: got %h want 0", host_waitrequest); end
    host_read = 1'b0;
    tick();
    n_rst = 1'b1;
    tick();
    n_rst = 1'b0;
    #1;
    vecs++; if (host_readdatavalid !== 1'b0 || host_waitrequest !== 1'b1) begin errs++; $display("FAIL abort_rd_t2: got v=%h wr=%h want 0 1", host_readdatavalid, host_waitrequest); end
    tick();
    vecs++; if (host_readdatavalid !== 1'b0 || mem_re !== 1'b0 || host_waitrequest !== 1'b1) begin errs++; $display("FAIL abort_rd_t3: got v=%h re=%h wr=%h want 0 0 1", host_readdatavalid, mem_re, host_waitrequest); end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_host_read();
    test_contention();
    test_overflow();
    test_clear();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
